// File: rtl/posit_encoder_pkg.sv
// Shared types and helpers for the posit encoder back end.
package posit_encoder_pkg;

  localparam int unsigned DEF_WIDTH = 7;
  localparam int unsigned DEF_EN    = 1;

  typedef enum logic [1:0] {IDLE, NORM, PACK, HOLD} posit_enc_state_t;
  typedef enum logic {POS, NEG} sign_t;

  // Largest positive posit pattern {0,1..1}, zero-extended to 32 bits.
  function automatic logic [31:0] posit_maxpos(input int unsigned width);
    return (32'd1 << (width - 1)) - 32'd1;
  endfunction

  // Smallest positive posit pattern {0..0,1}.
  function automatic logic [31:0] posit_minpos(input int unsigned width);
    return (width > 0) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] two_comp(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

endpackage

// File: rtl/posit_encoder_if.sv
// Valid/ready bundle between the mantissa adder, the posit encoder and its consumer.
interface posit_encoder_if
  import posit_encoder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned W_REG = $clog2(WIDTH),
  parameter int unsigned W_EXP = $clog2(WIDTH),
  parameter int unsigned W_MAN = WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [W_MAN-1:0] mantissa_sum;
  logic [W_REG-1:0] interim_regime;
  logic [W_EXP-1:0] interim_exponent;
  logic             negate_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;

  modport master (
    output in_valid, mantissa_sum, interim_regime, interim_exponent, negate_result, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, mantissa_sum, interim_regime, interim_exponent, negate_result, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/posit_encoder_packer.sv
// Combinational posit packer: regime run-length encode, saturation, optional rounding, negation.
// POSIT_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise the body is truncated.
module posit_encoder_packer
  import posit_encoder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned EN    = DEF_EN,
  parameter int unsigned W_MAN = WIDTH,
  parameter int unsigned W_K   = 8
) (
  input  logic signed [W_K-1:0] k,
  input  logic [W_MAN-1:0]      mant,
  input  logic                  negate,
  output logic [WIDTH-1:0]      word_c
);

  localparam int unsigned W_BODY = WIDTH - 1;
  localparam int unsigned W_TAIL = EN + W_MAN - 1;
  localparam int unsigned W_EXT  = W_BODY + W_TAIL;
  localparam int          R_MAX  = int'(WIDTH) - 2;
  localparam int          R_MIN  = 1 - int'(WIDTH);

  logic signed [W_K-1:0] r;
  int                    r_int;
  int                    rlen;
  logic [W_EXT-1:0]      regime_bits;
  logic [W_EXT-1:0]      tail_bits;
  logic [W_EXT-1:0]      ext;
  logic [W_BODY-1:0]     body;
  logic [WIDTH-1:0]      mag;
`ifdef POSIT_ROUND_NEAREST_EN
  logic                  guard;
  logic                  sticky;
`endif

  assign r         = k >>> EN;
  assign r_int     = int'(r);
  assign tail_bits = {k[EN-1:0], mant[W_MAN-2:0], {W_BODY{1'b0}}};

  // ext holds the full left-justified body; the top W_BODY bits are kept.
  always_comb begin
    regime_bits = '0;
    rlen        = 0;
    ext         = '0;
    body        = '0;
    mag         = '0;
`ifdef POSIT_ROUND_NEAREST_EN
    guard       = 1'b0;
    sticky      = 1'b0;
`endif
    if (r_int >= R_MAX) begin
      mag = WIDTH'(posit_maxpos(WIDTH));
    end else if (r_int <= R_MIN) begin
      mag = WIDTH'(posit_minpos(WIDTH));
    end else begin
      if (r_int >= 0) begin
        rlen        = r_int + 2;
        regime_bits = ~({W_EXT{1'b1}} >> (r_int + 1));
      end else begin
        rlen        = 1 - r_int;
        regime_bits = {{(W_EXT-1){1'b0}}, 1'b1} << (int'(W_EXT) - 1 + r_int);
      end
      ext  = regime_bits | (tail_bits >> rlen);
      body = W_BODY'(ext >> W_TAIL);
`ifdef POSIT_ROUND_NEAREST_EN
      guard  = ext[W_TAIL-1];
      sticky = |ext[W_TAIL-2:0];
      // A carry out of the all-ones body would land on NaR, so hold at maxpos.
      if (guard && (sticky || body[0]) && !(&body)) begin
        body = body + W_BODY'(1);
      end
`endif
      mag = {1'b0, body};
    end

    if (!mant[W_MAN-1]) begin
      word_c = '0;
    end else if (negate) begin
      word_c = WIDTH'(two_comp(32'(mag)));
    end else begin
      word_c = mag;
    end
  end

endmodule

// File: rtl/posit_encoder.sv
// Posit encoder: capture, iterative normalise (one bit per cycle), pack, hold until consumed.
// Rounding mode is selected by POSIT_ROUND_NEAREST_EN inside the packer.
module posit_encoder
  import posit_encoder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned EN    = DEF_EN,
  parameter int unsigned W_REG = $clog2(WIDTH),
  parameter int unsigned W_EXP = $clog2(WIDTH),
  parameter int unsigned W_MAN = WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  posit_encoder_if.slave  bus
);

  localparam int unsigned W_K = W_REG + EN + $clog2(W_MAN) + 1;

  posit_enc_state_t      state;
  logic signed [W_K-1:0] k_q;
  logic [W_MAN-1:0]      mant_q;
  sign_t                 sign_q;

  logic signed [W_REG-1:0] regime_s;
  logic signed [W_EXP-1:0] exponent_s;
  logic signed [W_K-1:0]   k_in_c;
  logic [WIDTH-1:0]        word_c;

  assign regime_s   = bus.interim_regime;
  assign exponent_s = bus.interim_exponent;
  assign k_in_c     = (W_K'(regime_s) <<< EN) + W_K'(exponent_s);

  posit_encoder_packer #(
    .WIDTH (WIDTH),
    .EN    (EN),
    .W_MAN (W_MAN),
    .W_K   (W_K)
  ) u_packer (
    .k      (k_q),
    .mant   (mant_q),
    .negate (sign_q == NEG),
    .word_c (word_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      k_q           <= '0;
      mant_q        <= '0;
      sign_q        <= POS;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            k_q          <= k_in_c;
            mant_q       <= bus.mantissa_sum;
            sign_q       <= bus.negate_result ? NEG : POS;
            bus.in_ready <= 1'b0;
            // Zero and already-normalised mantissas skip the shifter entirely.
            state <= ((bus.mantissa_sum == '0) || bus.mantissa_sum[W_MAN-1]) ? PACK : NORM;
          end
        end
        NORM: begin
          mant_q <= mant_q << 1;
          k_q    <= k_q - W_K'(1);
          if (mant_q[W_MAN-2]) begin
            state <= PACK;
          end
        end
        PACK: begin
          bus.result    <= word_c;
          bus.out_valid <= 1'b1;
          state         <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_posit_encoder.sv
// Directed and randomised checks of posit_encoder (WIDTH=7, EN=1) against a bit-string posit model.
module tb_posit_encoder;

  localparam int unsigned WIDTH = 7;
  localparam int unsigned EN    = 1;
  localparam int unsigned W_REG = 3;
  localparam int unsigned W_EXP = 3;
  localparam int unsigned W_MAN = 7;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  posit_encoder_if #(.WIDTH(WIDTH), .W_REG(W_REG), .W_EXP(W_EXP), .W_MAN(W_MAN)) bus ();

  posit_encoder #(
    .WIDTH (WIDTH),
    .EN    (EN),
    .W_REG (W_REG),
    .W_EXP (W_EXP),
    .W_MAN (W_MAN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Posit built as a bit string from the scale k = regime*2 + exponent and a normalised significand.
  function automatic void ref_model(input int m, input int rg, input int ex, input bit neg,
                                    output logic [6:0] w, output int lat);
    int k, r, e, lz;
    bit bits[$];
    lz = 0;
    w  = '0;
    if (m == 0) begin
      lat = 2;
      return;
    end
    k = rg * 2 + ex;
    while (m < 64) begin
      m  = m * 2;
      k  = k - 1;
      lz = lz + 1;
    end
    lat = 2 + lz;
    e   = ((k % 2) + 2) % 2;
    r   = (k - e) / 2;
    if (r >= 5) begin
      w = 7'b0111111;
    end else if (r <= -6) begin
      w = 7'b0000001;
    end else begin
      if (r >= 0) begin
        repeat (r + 1) bits.push_back(1'b1);
        bits.push_back(1'b0);
      end else begin
        repeat (-r) bits.push_back(1'b0);
        bits.push_back(1'b1);
      end
      bits.push_back(e[0]);
      for (int i = 5; i >= 0; i--) bits.push_back(m[i]);
      for (int i = 0; i < 6; i++) w[5-i] = bits[i];
    end
    if (neg) w = ~w + 7'd1;
  endfunction

  task automatic run_op(input string tag, input int m, input int rg, input int ex, input bit neg,
                        input logic [6:0] exp_word, input int exp_lat, input int hold, input bit poke);
    int cyc;
    @(negedge clk);
    check({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.mantissa_sum     = 7'(m);
    bus.interim_regime   = 3'(rg);
    bus.interim_exponent = 3'(ex);
    bus.negate_result    = neg;
    bus.in_valid         = 1'b1;
    bus.out_ready        = (hold == 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    cyc = 1;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_in_ready_busy"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_result"}, 32'(bus.result), 32'(exp_word));
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        bus.in_valid     = 1'b1;
        bus.mantissa_sum = 7'($urandom_range(1, 127));
      end
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_hold_result"}, 32'(bus.result), 32'(exp_word));
      check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_post_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic run_random(input int idx);
    int m, rg, ex, lat, hold;
    bit neg, poke;
    logic [6:0] w;
    m    = int'($urandom_range(0, 127)) >> $urandom_range(0, 6);
    rg   = int'($urandom_range(0, 7)) - 4;
    ex   = int'($urandom_range(0, 7)) - 4;
    neg  = 1'($urandom_range(0, 1));
    hold = int'($urandom_range(0, 3));
    poke = 1'($urandom_range(0, 1));
    ref_model(m, rg, ex, neg, w, lat);
    run_op($sformatf("rand%0d", idx), m, rg, ex, neg, w, lat, hold, poke);
  endtask

  initial begin
    rst                  = 1'b1;
    bus.in_valid         = 1'b0;
    bus.mantissa_sum     = '0;
    bus.interim_regime   = '0;
    bus.interim_exponent = '0;
    bus.negate_result    = 1'b0;
    bus.out_ready        = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_result", 32'(bus.result), 32'd0);
    rst = 1'b0;

    run_op("one",        64,  0, 0, 1'b0, 7'b0100000, 2, 0, 1'b0);
    run_op("quarter",    16,  0, 0, 1'b0, 7'b0010000, 4, 0, 1'b0);
    run_op("neg_one",    64,  0, 0, 1'b1, 7'b1100000, 2, 0, 1'b0);
    run_op("zero_neg",    0,  0, 0, 1'b1, 7'b0000000, 2, 0, 1'b0);
    run_op("minpos",      1, -4, 0, 1'b0, 7'b0000001, 8, 0, 1'b0);
    run_op("big",        64,  3, 1, 1'b0, 7'b0111101, 2, 0, 1'b0);
    run_op("backpress",  64,  3, 1, 1'b0, 7'b0111101, 2, 5, 1'b1);

    // Reset in the middle of normalisation abandons the operation.
    @(negedge clk);
    bus.mantissa_sum     = 7'd1;
    bus.interim_regime   = '0;
    bus.interim_exponent = '0;
    bus.negate_result    = 1'b0;
    bus.in_valid         = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_norm_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_norm_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_norm_result", 32'(bus.result), 32'd0);
    repeat (8) @(negedge clk);
    check("rst_norm_no_emit", 32'(bus.out_valid), 32'd0);
    run_op("after_rst",  16,  0, 0, 1'b0, 7'b0010000, 4, 0, 1'b0);

    for (int i = 0; i < 40; i++) run_random(i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
